// File: rtl/mdu_hilo.sv
// mdu_hilo: MIPS multiply/divide unit with HI/LO registers and a start/busy/done handshake.
// Define MDU_ITER_MUL_EN to use an iterative shift-add multiplier; it is combinational otherwise.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_DIV = CW'(WIDTH - 1);
`ifdef MDU_ITER_MUL_EN
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH - 1);
`else
  localparam logic [CW-1:0] CNT_MUL = '0;
`endif
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return neg ? -sv : sv;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    logic signed [2*WIDTH-1:0] sv;
    sv = $signed(v);
    return neg ? -sv : sv;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sgn_op, sa, sb, b_zero;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;
`ifdef MDU_ITER_MUL_EN
  logic [WIDTH:0]   mul_sum;
`else
  logic [2*WIDTH-1:0] prod;
`endif

  // One iteration of the datapath. acc_lo holds the dividend/multiplier bits being consumed.
  // With a zero divisor every compare succeeds, so the dividend rotates back into acc_hi and
  // the quotient fills with ones: exactly the required divide-by-zero result.
  always_comb begin
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_sub   = div_shift[WIDTH-1:0] - opb_q;
`ifdef MDU_ITER_MUL_EN
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
`else
    prod      = {{WIDTH{1'b0}}, acc_lo_q} * {{WIDTH{1'b0}}, opb_q};
`endif
    if (is_div_q) begin
      step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
`ifdef MDU_ITER_MUL_EN
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`else
      step_hi = prod[2*WIDTH-1:WIDTH];
      step_lo = prod[WIDTH-1:0];
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sgn_op   = (op == OP_MULT) || (op == OP_DIV);
    b_zero   = (b == '0);
    sb       = b[WIDTH-1] & sgn_op;
    // Divide by zero skips the sign fixups, so the raw dividend must be latched.
    sa       = a[WIDTH-1] & sgn_op & ~(b_zero && (op == OP_DIV));
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d = (op == OP_DIV) || (op == OP_DIVU);
              acc_hi_d = '0;
              acc_lo_d = cond_neg(a, sa);
              opb_d    = cond_neg(b, sb);
              neg_lo_d = sa ^ sb;
              neg_hi_d = sa;
              cnt_d    = is_div_d ? CNT_DIV : CNT_MUL;
              state_d  = S_BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == '0) begin
            if (is_div_q) begin
              hi_d = cond_neg(step_hi, neg_hi_q);
              lo_d = cond_neg(step_lo, neg_lo_q);
            end else begin
              {hi_d, lo_d} = cond_neg2({step_hi, step_lo}, neg_lo_q);
            end
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign done = (state_q == S_DONE);
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed-vector bench for mdu_hilo: result table plus reset, cancel and DONE-window sequences.
module tb_mdu_hilo;
  localparam int W = 32;
`ifdef MDU_ITER_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 2;
`endif
  localparam int DIV_LAT = W + 1;
  localparam int NV      = 13;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSV   = 3'd7;

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi_o, lo_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } vec_t;

  vec_t vecs [NV];

  mdu_hilo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cancel(cancel),
    .a(a), .b(b), .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after E0; returns edges after E0 until done is seen, and busy cycles seen.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!done && n < 200) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
    check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int nbusy);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; op = OP_NOP; a = $urandom; b = $urandom;
    wait_done(n, nbusy);
    lat = n + 1;
  endtask

  initial begin
    int lat, nb, n;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = OP_NOP; a = '0; b = '0;

    vecs[0]  = '{OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14,         DIV_LAT};
    vecs[1]  = '{OP_DIV,   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   DIV_LAT};
    vecs[2]  = '{OP_DIV,   32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000,   DIV_LAT};
    vecs[3]  = '{OP_MULT,  32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFE,   MUL_LAT};
    vecs[4]  = '{OP_MULTU, 32'hFFFFFFFF,   32'd2,          32'h1,          32'hFFFFFFFE,   MUL_LAT};
    vecs[5]  = '{OP_DIVU,  32'd5,          32'd0,          32'd5,          32'hFFFFFFFF,   DIV_LAT};
    vecs[6]  = '{OP_DIV,   32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   DIV_LAT};
    vecs[7]  = '{OP_DIV,   32'hFFFFFFF8,   32'd0,          32'hFFFFFFF8,   32'hFFFFFFFF,   DIV_LAT};
    vecs[8]  = '{OP_MULT,  32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF,   32'h00000001,   MUL_LAT};
    vecs[9]  = '{OP_MULT,  32'h80000000,   32'h80000000,   32'h40000000,   32'h0,          MUL_LAT};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFFF,   32'd1,          32'h0,          32'hFFFFFFFF,   DIV_LAT};
    vecs[11] = '{OP_MULT,  32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF,   32'hFFFFFFF1,   MUL_LAT};
    vecs[12] = '{OP_DIV,   32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd14,         DIV_LAT};

    tick();
    tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi_o}, 64'd0);
    check("reset_lo", {32'd0, lo_o}, 64'd0);
    rst = 1'b1;
    tick();

    // Requests that must not leave IDLE
    op = OP_NOP; start = 1'b1; tick();
    check("nop_ignored", {63'd0, busy}, 64'd0);
    op = OP_RSV; tick();
    check("rsv_ignored", {63'd0, busy}, 64'd0);
    op = OP_DIVU; a = 32'd9; b = 32'd3; cancel = 1'b1; tick();
    check("start_cancel_ignored", {63'd0, busy}, 64'd0);
    cancel = 1'b0; start = 1'b0; op = OP_NOP;

    op = OP_MTHI; a = 32'h11; start = 1'b1; tick();
    check("mthi_hi", {32'd0, hi_o}, 64'h11);
    check("mthi_no_done", {62'd0, busy, done}, 64'd0);
    op = OP_MTLO; a = 32'h22; tick();
    check("mtlo_lo", {32'd0, lo_o}, 64'h22);
    check("mtlo_hi_kept", {32'd0, hi_o}, 64'h11);
    start = 1'b0; op = OP_NOP;

    // Cancel in the 10th busy cycle
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1; tick();
    start = 1'b0; op = OP_NOP;
    repeat (9) tick();
    check("cancel_busy_before", {63'd0, busy}, 64'd1);
    cancel = 1'b1; tick(); cancel = 1'b0;
    check("cancel_state", {62'd0, busy, done}, 64'd0);
    check("cancel_hi", {32'd0, hi_o}, 64'h11);
    check("cancel_lo", {32'd0, lo_o}, 64'h22);
    run_op(OP_DIVU, 32'd9, 32'd3, lat, nb);
    check("after_cancel_lat", 64'(lat), 64'(DIV_LAT));
    check("after_cancel_lo", {32'd0, lo_o}, 64'd3);
    check("after_cancel_hi", {32'd0, hi_o}, 64'd0);
    tick();

    // start and cancel during DONE are both ignored
    run_op(OP_DIVU, 32'd100, 32'd7, lat, nb);
    op = OP_DIVU; a = 32'd50; b = 32'd5; start = 1'b1; cancel = 1'b1; tick();
    start = 1'b0; cancel = 1'b0; op = OP_NOP;
    check("done_start_ignored", {62'd0, busy, done}, 64'd0);
    check("done_hi_kept", {32'd0, hi_o}, 64'd2);
    check("done_lo_kept", {32'd0, lo_o}, 64'd14);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nb);
      check($sformatf("v%0d_hi", i), {32'd0, hi_o}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i), {32'd0, lo_o}, {32'd0, vecs[i].lo});
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 64'(nb), 64'(vecs[i].lat - 1));
      tick();
      check($sformatf("v%0d_done_pulse", i), {62'd0, busy, done}, 64'd0);
    end

    // Asynchronous reset in the middle of a divide
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1; tick();
    start = 1'b0; op = OP_NOP;
    repeat (5) tick();
    rst = 1'b0;
    #2;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_hi", {32'd0, hi_o}, 64'd0);
    check("midrst_lo", {32'd0, lo_o}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    run_op(OP_DIVU, 32'd100, 32'd7, lat, nb);
    check("post_rst_lat", 64'(lat), 64'(DIV_LAT));
    check("post_rst_lo", {32'd0, lo_o}, 64'd14);
    check("post_rst_hi", {32'd0, hi_o}, 64'd2);
    n = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Parametrised multiply/divide unit with integrated HI/LO registers for the execute stage of the pipelined MIPS core. It covers MULT/MULTU/DIV/DIVU/MTHI/MTLO behind one start/busy/done handshake. `busy` drives the execute-stage stall. A `cancel` input aborts in-flight operations when the exception logic flushes the pipeline. Operand width and multiplier implementation are configurable.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits. Must be even and ≥ 4.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  operation code:
  - 0 NOP
  - 1 MULT
  - 2 MULTU
  - 3 DIV
  - 4 DIVU
  - 5 MTHI
  - 6 MTLO
  - 7 reserved, treated as NOP.
- `cancel`  in  1  abort the operation in flight (exception flush).
- `a`  in  WIDTH  rs operand / dividend / MTHI-MTLO data.
- `b`  in  WIDTH  rt operand / divisor.
- `busy`  out  1  high while state is BUSY.
- `done`  out  1  one-cycle pulse; HI/LO already hold the new result.
- `hi_o`  out  WIDTH  HI register.
- `lo_o`  out  WIDTH  LO register.

## Operation
- States are IDLE, BUSY and DONE.
- IDLE:
  - `start` with op 1–4 and `cancel`=0: latch operands and sign info, load the iteration counter, go to BUSY.
  - `start` with op 5/6: write `a` into HI/LO at that edge and stay in IDLE. No `done` pulse.
  - NOP or reserved op: ignored.
  - `start` with `cancel`=1: ignored.
- BUSY:
  - Counter decrements each cycle; at 0, write HI/LO and go to DONE.
  - `cancel`=1 in any BUSY cycle: go to IDLE at the next edge. HI/LO are not written and no `done` is issued.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE. `cancel` in DONE has no effect, because the result is already committed.
- Division is radix-2 restoring, one quotient bit per cycle, on absolute values:
  - Quotient is negated when operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (DIV only).
  - Most-negative / −1: LO = 1 followed by WIDTH−1 zeros, HI = 0 (no trap).
  - Divide by zero (DIV or DIVU): LO = all ones, HI = `a`, with no sign fixup.
- Multiplication produces a 2·WIDTH-bit product: HI = upper half, LO = lower half. MULT is signed, MULTU is unsigned.
- `op` and operands are relevant only in the `start` cycle. They may change freely during BUSY.

## Timing
- Reset (`rst`=0, asynchronous):
  - State IDLE.
  - `busy`=0 and `done`=0.
  - `hi_o`=0 and `lo_o`=0.
  - Counter and operand latches are cleared.
- Let E0 be the edge that accepts `start`:
  - Divide: BUSY for WIDTH cycles. HI/LO are written at edge E0+WIDTH. `done` is high in the cycle after that edge. Total latency is WIDTH+1 cycles.
  - Multiply: see Configuration.
- MTHI/MTLO: `hi_o`/`lo_o` update at E0. They are visible the following cycle.
- `busy` is low during DONE, so the stalled instruction advances while `done` is high.
- A new `start` can be accepted in the cycle after DONE.
- A new `start` can be accepted in the cycle after a cancel.
- Reset asserted mid-operation: immediate return to the reset state, and any partial result is discarded.

## Configuration
- Macro `MDU_ITER_MUL_EN`:
  - Defined: multiply is iterative radix-2 shift-add on absolute values, with a final sign fixup for MULT. BUSY lasts WIDTH cycles, giving the same WIDTH+1 latency as divide. No hardware multiplier is inferred.
  - Undefined: the product is computed combinationally from the latched operands. BUSY lasts exactly 1 cycle. `done` fires 2 cycles after E0.
- Handshake, cancel semantics and results are identical in both builds.

## Test plan
- Reset:
  - Drive `rst`=0 mid-DIVU.
  - Required: `busy`=0, `done`=0, `hi_o`=`lo_o`=0 immediately.
  - After release, an IDLE `start` is accepted.
- DIVU:
  - Stimulus: `a`=100, `b`=7, WIDTH=32.
  - Required: `busy` high for 32 cycles, `done` pulses in cycle 33.
  - Required: `lo_o`=14, `hi_o`=2.
- DIV signed cases:
  - `a`=−7 (0xFFFFFFF9), `b`=2: `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF.
  - `a`=0x80000000, `b`=0xFFFFFFFF: `lo_o`=0x80000000, `hi_o`=0.
- Multiply, with `a`=0xFFFFFFFF, `b`=2:
  - MULT: `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFFE.
  - MULTU: `hi_o`=1, `lo_o`=0xFFFFFFFE.
  - Latency: 33 cycles with `MDU_ITER_MUL_EN` defined, 2 cycles without.
- Cancel:
  - Preload HI=0x11, LO=0x22 via MTHI/MTLO.
  - Start DIVU and assert `cancel` in the 10th BUSY cycle.
  - Required: no `done`, HI/LO still 0x11/0x22.
  - A start issued the next cycle is accepted.
  - A `start` issued during DONE is ignored.
- Divide by zero: DIVU `a`=5, `b`=0 → `lo_o`=0xFFFFFFFF, `hi_o`=5, `done` after 33 cycles.
